// File: rtl/alu_issue_pkg.sv
// Shared constants, instruction field positions and types for the alu_issue front-end.
package alu_issue_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned IMM_W = 12;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned F3_LSB  = 12;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned F7_LSB  = 25;
    localparam int unsigned IMM_LSB = 20;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    localparam logic [F3_W-1:0] F3_ADD = 3'b000;
    localparam logic [F3_W-1:0] F3_SLL = 3'b001;
    localparam logic [F3_W-1:0] F3_SR  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RES  = 2'd2
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [XLEN-1:0]  imm;
        logic             useImm;
        logic             legal;
    } decode_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational OP/OP-IMM decode: field extraction, immediate build, funct7 selection, legality.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [XLEN-1:0] iInstr,
    output decode_t         oDec
);

    logic [OPC_W-1:0] opcode;
    logic [F3_W-1:0]  f3;
    logic [F7_W-1:0]  f7Raw;
    logic             isShift;

    always_comb begin
        opcode  = iInstr[OPC_LSB +: OPC_W];
        f3      = iInstr[F3_LSB +: F3_W];
        f7Raw   = iInstr[F7_LSB +: F7_W];
        isShift = (f3 == F3_SLL) || (f3 == F3_SR);

        oDec        = '0;
        oDec.rd     = iInstr[RD_LSB +: REG_W];
        oDec.rs1    = iInstr[RS1_LSB +: REG_W];
        oDec.rs2    = iInstr[RS2_LSB +: REG_W];
        oDec.funct3 = f3;

        case (opcode)
            OPC_OP: begin
                oDec.funct7 = f7Raw;
                oDec.legal  = (f7Raw == F7_BASE) ||
                              ((f7Raw == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
            end
            OPC_OP_IMM: begin
                oDec.useImm = 1'b1;
                if (isShift) begin
                    // Shift-immediates carry funct7 in the upper immediate bits; only shamt reaches B.
                    oDec.imm    = XLEN'(iInstr[RS2_LSB +: REG_W]);
                    oDec.funct7 = f7Raw;
                    oDec.legal  = (f7Raw == F7_BASE) || ((f3 == F3_SR) && (f7Raw == F7_ALT));
                end else begin
                    oDec.imm    = {{(XLEN-IMM_W){iInstr[XLEN-1]}}, iInstr[IMM_LSB +: IMM_W]};
                    oDec.funct7 = F7_BASE;
                    oDec.legal  = 1'b1;
                end
            end
            default: oDec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// RV32I ALU issue/writeback front-end: captures operands, drives an external ALU, registers its result.
// Optional operand forwarding from the pending writeback: define ALU_ISSUE_FWD_EN.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic [XLEN-1:0]   iInstr,
    input  logic [XLEN-1:0]   iRs1Data,
    input  logic [XLEN-1:0]   iRs2Data,
    output logic [XLEN-1:0]   oAluA,
    output logic [XLEN-1:0]   oAluB,
    output logic [F3_W-1:0]   oAluFunct3,
    output logic [F7_W-1:0]   oAluFunct7,
    input  logic [XLEN-1:0]   iAluData,
    input  logic              iAluZero,
    output logic              oValid,
    input  logic              iReady,
    output logic [REG_W-1:0]  oRd,
    output logic [XLEN-1:0]   oData,
    output logic              oZero,
    output logic              oWe,
    output logic              oIllegal
);

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    state_t           state;
    decode_t          dec;
    logic [REG_W-1:0] rdQ;
    logic             legalQ;
    logic             accept;
    logic [XLEN-1:0]  opA;
    logic [XLEN-1:0]  opB;

    alu_issue_decode uDecode (
        .iInstr (iInstr),
        .oDec   (dec)
    );

    assign oReady = (state == IDLE) | ((state == RES) & iReady);
    assign accept = iValid & oReady;

    // Operand select; a forwarded value only ever comes from the result being retired this cycle.
    always_comb begin
        opA = iRs1Data;
        opB = dec.useImm ? dec.imm : iRs2Data;
        if (FWD_EN && (state == RES) && oWe) begin
            if (dec.rs1 == oRd) opA = oData;
            if (!dec.useImm && (dec.rs2 == oRd)) opB = oData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= IDLE;
            oAluA      <= '0;
            oAluB      <= '0;
            oAluFunct3 <= '0;
            oAluFunct7 <= '0;
            rdQ        <= '0;
            legalQ     <= 1'b0;
            oValid     <= 1'b0;
            oRd        <= '0;
            oData      <= '0;
            oZero      <= 1'b0;
            oWe        <= 1'b0;
            oIllegal   <= 1'b0;
        end else begin
            if (accept) begin
                oAluA      <= opA;
                oAluB      <= opB;
                oAluFunct3 <= dec.funct3;
                oAluFunct7 <= dec.funct7;
                rdQ        <= dec.rd;
                legalQ     <= dec.legal;
            end
            case (state)
                IDLE: begin
                    if (iValid) state <= EXEC;
                end
                EXEC: begin
                    // Rejected instructions report a zero result regardless of what the ALU produced.
                    oData    <= legalQ ? iAluData : '0;
                    oZero    <= legalQ ? iAluZero : 1'b1;
                    oWe      <= legalQ & (rdQ != '0);
                    oIllegal <= ~legalQ;
                    oRd      <= rdQ;
                    oValid   <= 1'b1;
                    state    <= RES;
                end
                RES: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        state  <= iValid ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
